hippo_rvfi_monitor: RTL and testbench

//   Consumer end of the core's RVFI retirement stream. Sits beside hippomenes_veryl_HippoTop in simulation/FPGA debug builds.

---
 rtl/hippo_rvfi_pkg.sv | 31 +++
 rtl/hippo_rvfi_fifo.sv | 60 ++++++
 rtl/hippo_rvfi_monitor.sv | 170 +++++++++++++++++
 tb/tb_hippo_rvfi_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hippo_rvfi_pkg.sv
// Shared types for the RVFI retirement monitor: error codes, monitor states
// and the packed trace record pushed into the drain FIFO.
package hippo_rvfi_pkg;

    localparam int REC_W = 84;

    typedef enum logic [3:0] {
        ERR_NONE  = 4'd0,
        ERR_ORDER = 4'd1,
        ERR_PC    = 4'd2,
        ERR_RS1   = 4'd3,
        ERR_RS2   = 4'd4,
        ERR_RD0   = 4'd5,
        ERR_WMASK = 4'd6
    } err_code_t;

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } mon_state_t;

    typedef struct packed {
        logic [15:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [3:0]  err;
    } trace_rec_t;

endpackage

// File: rtl/hippo_rvfi_fifo.sv
// Synchronous first-word-fall-through FIFO for trace records.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module hippo_rvfi_fifo #(
    parameter int Width = 84,
    parameter int Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(Depth));
    assign data_o  = mem_q[rdPtr_q];
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // Storage array is written on accepted pushes; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hippo_rvfi_monitor.sv
// RVFI retirement stream consumer: shadow register file, per-beat consistency
// checks with first-error latching, and a trace record FIFO drained by valid/ready.
module hippo_rvfi_monitor
    import hippo_rvfi_pkg::*;
#(
    parameter int          FifoDepth = 8,
    parameter logic [31:0] ResetPc   = 32'h0,
    parameter logic [31:0] RegMask   = 32'hFFFFFFE6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rvfi_valid,
    input  logic [63:0]       rvfi_order,
    input  logic [31:0]       rvfi_insn,
    input  logic              rvfi_halt,
    input  logic [4:0]        rvfi_rs1_addr,
    input  logic [4:0]        rvfi_rs2_addr,
    input  logic [31:0]       rvfi_rs1_rdata,
    input  logic [31:0]       rvfi_rs2_rdata,
    input  logic [4:0]        rvfi_rd_addr,
    input  logic [31:0]       rvfi_rd_wdata,
    input  logic [31:0]       rvfi_pc_rdata,
    input  logic [31:0]       rvfi_pc_wdata,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [REC_W-1:0]  rec_data_o,
    output logic              err_o,
    output logic [3:0]        err_code_o,
    output logic [63:0]       err_order_o,
    output logic [31:0]       retired_o,
    output logic              halted_o,
    output logic              overflow_o
);

    mon_state_t  state_q;
    mon_state_t  state_d;
    logic [31:0] shadow_q [32];
    logic [63:0] lastOrder_q;
    logic [31:0] lastPcW_q;
    logic [31:0] retired_q;
    logic        halted_q;
    logic        err_q;
    err_code_t   errCode_q;
    logic [63:0] errOrder_q;
    logic        overflow_q;

    logic        beatActive;
    err_code_t   errCode;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic        pcBad;
    trace_rec_t  rec;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        recPop;

    assign beatActive = rvfi_valid && (state_q == ST_FIRST || state_q == ST_RUN);
    assign recPop     = rec_valid_o && rec_ready_i;

    // Classify the incoming beat against pre-beat state; earlier checks win.
    always_comb begin
        errCode = ERR_NONE;
        rs1Val  = RegMask[rvfi_rs1_addr] ? shadow_q[rvfi_rs1_addr] : 32'd0;
        rs2Val  = RegMask[rvfi_rs2_addr] ? shadow_q[rvfi_rs2_addr] : 32'd0;
        pcBad   = (state_q == ST_FIRST) ? (rvfi_pc_rdata != ResetPc)
                                        : (rvfi_pc_rdata != lastPcW_q);
        if (state_q == ST_RUN && rvfi_order <= lastOrder_q) begin
            errCode = ERR_ORDER;
        end else if (pcBad) begin
            errCode = ERR_PC;
        end else if (rvfi_rs1_rdata != rs1Val) begin
            errCode = ERR_RS1;
        end else if (rvfi_rs2_rdata != rs2Val) begin
            errCode = ERR_RS2;
        end else if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) begin
            errCode = ERR_RD0;
        end else if (!RegMask[rvfi_rd_addr] && rvfi_rd_wdata != 32'd0) begin
            errCode = ERR_WMASK;
        end
    end

    // Next monitor state: an error takes precedence over a halt on the same beat.
    always_comb begin
        state_d = state_q;
        if (beatActive) begin
            if (errCode != ERR_NONE) begin
                state_d = ST_ERROR;
            end else if (rvfi_halt) begin
                state_d = ST_HALTED;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // Compact trace record built from the beat and its check result.
    always_comb begin
        rec.order = rvfi_order[15:0];
        rec.pc    = rvfi_pc_rdata;
        rec.insn  = rvfi_insn;
        rec.err   = errCode;
    end

    // Shadow register file follows every processed beat, erroring or not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= 32'd0;
            end
        end else if (beatActive && rvfi_rd_addr != 5'd0 && RegMask[rvfi_rd_addr]) begin
            shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
        end
    end

    // Monitor state plus registered status outputs, sticky flags and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FIRST;
            lastOrder_q <= 64'd0;
            lastPcW_q   <= 32'd0;
            retired_q   <= 32'd0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            errCode_q   <= ERR_NONE;
            errOrder_q  <= 64'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beatActive) begin
                lastOrder_q <= rvfi_order;
                lastPcW_q   <= rvfi_pc_wdata;
                retired_q   <= retired_q + 32'd1;
                if (rvfi_halt) begin
                    halted_q <= 1'b1;
                end
                if (errCode != ERR_NONE) begin
                    err_q      <= 1'b1;
                    errCode_q  <= errCode;
                    errOrder_q <= rvfi_order;
                end
                if (fifoFull && !recPop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    hippo_rvfi_fifo #(
        .Width (REC_W),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (beatActive),
        .data_i  (rec),
        .full_o  (fifoFull),
        .pop_i   (recPop),
        .data_o  (rec_data_o),
        .empty_o (fifoEmpty)
    );

    assign rec_valid_o = !fifoEmpty;
    assign err_o       = err_q;
    assign err_code_o  = errCode_q;
    assign err_order_o = errOrder_q;
    assign retired_o   = retired_q;
    assign halted_o    = halted_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_hippo_rvfi_monitor.sv
// Directed bench for hippo_rvfi_monitor. Stimulus pushes expected trace
// records into a queue; an independent monitor pops and compares drained records.
module tb_hippo_rvfi_monitor;

    logic        clk;
    logic        rst;
    logic        rvfiValid;
    logic [63:0] rvfiOrder;
    logic [31:0] rvfiInsn;
    logic        rvfiHalt;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic [31:0] pcR;
    logic [31:0] pcW;
    logic        recValid;
    logic        recReady;
    logic [83:0] recData;
    logic        errFlag;
    logic [3:0]  errCode;
    logic [63:0] errOrder;
    logic [31:0] retired;
    logic        halted;
    logic        overflow;

    int tests = 0;
    int failures = 0;
    logic [83:0] expQ [$];

    hippo_rvfi_monitor #(
        .FifoDepth (8),
        .ResetPc   (32'h0),
        .RegMask   (32'hFFFFFFE6)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rvfi_valid     (rvfiValid),
        .rvfi_order     (rvfiOrder),
        .rvfi_insn      (rvfiInsn),
        .rvfi_halt      (rvfiHalt),
        .rvfi_rs1_addr  (rs1Addr),
        .rvfi_rs2_addr  (rs2Addr),
        .rvfi_rs1_rdata (rs1Data),
        .rvfi_rs2_rdata (rs2Data),
        .rvfi_rd_addr   (rdAddr),
        .rvfi_rd_wdata  (rdData),
        .rvfi_pc_rdata  (pcR),
        .rvfi_pc_wdata  (pcW),
        .rec_valid_o    (recValid),
        .rec_ready_i    (recReady),
        .rec_data_o     (recData),
        .err_o          (errFlag),
        .err_code_o     (errCode),
        .err_order_o    (errOrder),
        .retired_o      (retired),
        .halted_o       (halted),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every record the DUT hands over must match the queue head.
    always @(negedge clk) begin
        if (!rst && recValid && recReady) begin
            tests++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL rec_unexpected: got 0x%0h expected no record", recData);
            end else begin
                logic [83:0] exp;
                exp = expQ.pop_front();
                if (recData !== exp) begin
                    failures++;
                    $display("[TB] FAIL rec_data: got 0x%0h expected 0x%0h", recData, exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] pcNext,
                                 input logic [31:0] insn, input logic [4:0] rs1a, input logic [31:0] rs1d,
                                 input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [4:0] rda,
                                 input logic [31:0] rdw, input logic halt, input logic [3:0] expErr,
                                 input logic expectRec);
        rvfiValid = 1'b1;
        rvfiOrder = order;
        pcR       = pc;
        pcW       = pcNext;
        rvfiInsn  = insn;
        rs1Addr   = rs1a;
        rs1Data   = rs1d;
        rs2Addr   = rs2a;
        rs2Data   = rs2d;
        rdAddr    = rda;
        rdData    = rdw;
        rvfiHalt  = halt;
        if (expectRec) expQ.push_back({order[15:0], pc, insn, expErr});
        @(posedge clk);
        #1;
        rvfiValid = 1'b0;
        rvfiHalt  = 1'b0;
    endtask

    task automatic nopBeat(input logic [63:0] order, input logic [31:0] pc, input logic halt,
                           input logic [3:0] expErr, input logic expectRec);
        applyStimulus(order, pc, pc + 32'd4, 32'h00000013, 5'd0, 32'd0, 5'd0, 32'd0,
                      5'd0, 32'd0, halt, expErr, expectRec);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        rvfiValid = 1'b0;
        rvfiHalt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_left"}, 64'(expQ.size()), 64'd0);
        checkOutput({name, "_valid"}, 64'(recValid), 64'd0);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_err"}, 64'(errFlag), 64'd0);
        checkOutput({name, "_code"}, 64'(errCode), 64'd0);
        checkOutput({name, "_eorder"}, errOrder, 64'd0);
        checkOutput({name, "_retired"}, 64'(retired), 64'd0);
        checkOutput({name, "_halted"}, 64'(halted), 64'd0);
        checkOutput({name, "_ovf"}, 64'(overflow), 64'd0);
        checkOutput({name, "_recvalid"}, 64'(recValid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; rvfiValid = 1'b0; rvfiOrder = '0; rvfiInsn = '0; rvfiHalt = 1'b0;
        rs1Addr = '0; rs2Addr = '0; rs1Data = '0; rs2Data = '0; rdAddr = '0; rdData = '0;
        pcR = '0; pcW = '0; recReady = 1'b1;

        // Clean sequence: addi x5,x0,7 then add x6,x5,x0 then two nops
        resetDut();
        checkIdleOutputs("reset");
        applyStimulus(64'd0, 32'd0, 32'd4, 32'h00700293, 5'd0, 32'd0, 5'd7, 32'd0, 5'd5, 32'd7, 1'b0, 4'd0, 1'b1);
        applyStimulus(64'd1, 32'd4, 32'd8, 32'h00028333, 5'd5, 32'd7, 5'd0, 32'd0, 5'd6, 32'd7, 1'b0, 4'd0, 1'b1);
        nopBeat(64'd2, 32'd8, 1'b0, 4'd0, 1'b1);
        nopBeat(64'd3, 32'd12, 1'b0, 4'd0, 1'b1);
        checkOutput("t1_retired", 64'(retired), 64'd4);
        checkOutput("t1_err", 64'(errFlag), 64'd0);
        waitDrain("t1_drain");

        // Wrong first PC; later beats ignored
        resetDut();
        nopBeat(64'd0, 32'h10, 1'b0, 4'd2, 1'b1);
        checkOutput("t2_err", 64'(errFlag), 64'd1);
        checkOutput("t2_code", 64'(errCode), 64'd2);
        checkOutput("t2_eorder", errOrder, 64'd0);
        nopBeat(64'd1, 32'h14, 1'b0, 4'd0, 1'b0);
        nopBeat(64'd2, 32'h18, 1'b0, 4'd0, 1'b0);
        checkOutput("t2_retired", 64'(retired), 64'd1);
        waitDrain("t2_drain");

        // RS1 mismatch, then same beat with repeated order (ORDER wins)
        resetDut();
        applyStimulus(64'd0, 32'd0, 32'd4, 32'h05500293, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h55, 1'b0, 4'd0, 1'b1);
        applyStimulus(64'd1, 32'd4, 32'd8, 32'h00028333, 5'd5, 32'h54, 5'd0, 32'd0, 5'd6, 32'h54, 1'b0, 4'd3, 1'b1);
        checkOutput("t3_code_rs1", 64'(errCode), 64'd3);
        checkOutput("t3_eorder_rs1", errOrder, 64'd1);
        waitDrain("t3a_drain");
        resetDut();
        applyStimulus(64'd0, 32'd0, 32'd4, 32'h05500293, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h55, 1'b0, 4'd0, 1'b1);
        applyStimulus(64'd0, 32'd4, 32'd8, 32'h00028333, 5'd5, 32'h54, 5'd0, 32'd0, 5'd6, 32'h54, 1'b0, 4'd1, 1'b1);
        checkOutput("t3_code_order", 64'(errCode), 64'd1);
        checkOutput("t3_eorder_order", errOrder, 64'd0);
        waitDrain("t3b_drain");

        // Write to masked register x3
        resetDut();
        applyStimulus(64'd0, 32'd0, 32'd4, 32'h00900193, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'd9, 1'b0, 4'd6, 1'b1);
        checkOutput("t4_code_wmask", 64'(errCode), 64'd6);
        waitDrain("t4a_drain");
        // Nonzero write to x0
        resetDut();
        applyStimulus(64'd0, 32'd0, 32'd4, 32'h00100013, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd1, 1'b0, 4'd5, 1'b1);
        checkOutput("t4_code_rd0", 64'(errCode), 64'd5);
        waitDrain("t4b_drain");
        // Masked registers read as zero; nonzero read data from one is an RS1 error
        resetDut();
        applyStimulus(64'd0, 32'd0, 32'd4, 32'h00000193, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'd0, 1'b0, 4'd0, 1'b1);
        applyStimulus(64'd1, 32'd4, 32'd8, 32'h00318033, 5'd3, 32'd0, 5'd3, 32'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        checkOutput("t4_masked_read_ok", 64'(errFlag), 64'd0);
        applyStimulus(64'd2, 32'd8, 32'd12, 32'h00020033, 5'd4, 32'd1, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 4'd3, 1'b1);
        checkOutput("t4_masked_read_bad", 64'(errCode), 64'd3);
        checkOutput("t4_eorder", errOrder, 64'd2);
        waitDrain("t4c_drain");

        // Overflow: consumer stalled for 9 beats, then full+push+pop
        resetDut();
        recReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            nopBeat(64'(i), 32'(4 * i), 1'b0, 4'd0, (i < 8));
        end
        checkOutput("t5_recvalid", 64'(recValid), 64'd1);
        checkOutput("t5_overflow", 64'(overflow), 64'd1);
        checkOutput("t5_err", 64'(errFlag), 64'd0);
        checkOutput("t5_retired", 64'(retired), 64'd9);
        recReady = 1'b1;
        nopBeat(64'd9, 32'd36, 1'b0, 4'd0, 1'b1);
        checkOutput("t5_retired_after", 64'(retired), 64'd10);
        waitDrain("t5_drain");

        // Halt freezes the monitor; mid-run reset clears everything
        resetDut();
        recReady = 1'b0;
        nopBeat(64'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        nopBeat(64'd1, 32'd4, 1'b1, 4'd0, 1'b1);
        nopBeat(64'd2, 32'd8, 1'b0, 4'd0, 1'b0);
        nopBeat(64'd3, 32'd12, 1'b0, 4'd0, 1'b0);
        checkOutput("t6_halted", 64'(halted), 64'd1);
        checkOutput("t6_retired", 64'(retired), 64'd2);
        checkOutput("t6_err", 64'(errFlag), 64'd0);
        checkOutput("t6_recvalid", 64'(recValid), 64'd1);
        resetDut();
        recReady = 1'b1;
        checkIdleOutputs("t6_reset");
        nopBeat(64'd0, 32'd4, 1'b0, 4'd2, 1'b1);
        checkOutput("t6_first_pc_code", 64'(errCode), 64'd2);
        waitDrain("t6a_drain");
        // Halt and error on the same beat
        resetDut();
        nopBeat(64'd0, 32'd8, 1'b1, 4'd2, 1'b1);
        checkOutput("t6_he_code", 64'(errCode), 64'd2);
        checkOutput("t6_he_halted", 64'(halted), 64'd1);
        nopBeat(64'd1, 32'd12, 1'b0, 4'd0, 1'b0);
        checkOutput("t6_he_retired", 64'(retired), 64'd1);
        waitDrain("t6b_drain");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
